mult_txn_checker: RTL and testbench
===================================

Name: mult_txn_checker

Overview:
- Synthesizable on-chip monitor/scoreboard for the add-shift multiplier.
- Watches the multiplier's pin interface plus its internal operation state. Flags BAD_PRODUCT and NOT_READY protocol errors, counts them, and records functional coverage: operand pairs, plus reset/start asserted during ADD and SHIFT.
- Sits beside the multiplier in the test harness. It has its own reset so coverage survives multiplier resets.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH bits; operand pairs = 2^(2*WIDTH).
- CNT_W, 16, width of saturating error counters.

Ports:
- clk_i  in  1  clock shared with the multiplier.
- reset_n_i  in  1  checker reset; async, active-low; clears all checker state.
- dut_reset_n_i  in  1  multiplier's reset pin (observed only).
- multiplicand_i  in  WIDTH  multiplier operand A pin.
- multiplier_i  in  WIDTH  multiplier operand B pin.
- start_i  in  1  multiplier start pin.
- ready_o_mon  in  1  multiplier ready output.
- done_o_mon  in  1  multiplier done output.
- product_o_mon  in  2*WIDTH  multiplier product output.
- op_state_i  in  2  multiplier internal op (mult_op_t).
- bp_err_o  out  1  one-cycle BAD_PRODUCT pulse.
- nr_err_o  out  1  one-cycle NOT_READY pulse.
- bp_count_o  out  CNT_W  saturating BAD_PRODUCT count.
- nr_count_o  out  CNT_W  saturating NOT_READY count.
- cover_count_o  out  2*WIDTH+1  distinct operand pairs covered.
- all_covered_o  out  1  cover_count_o == 2^(2*WIDTH).
- reset_add_cov_o, reset_shift_cov_o, start_add_cov_o, start_shift_cov_o  out  1 each  sticky event covers.
- cov_qa_i, cov_qb_i  in  WIDTH each  coverage query operands.
- cov_hit_o  out  1  combinational: pair (cov_qa_i, cov_qb_i) covered.

Behaviour:
- Reset (reset_n_i low, async): all outputs, counters, cover bitmap, sticky covers and pending flags go to 0.
- Transaction accept: on a rising clk with dut_reset_n_i=1, start_i=1, ready_o_mon=1:
  - latch A=multiplicand_i and B=multiplier_i;
  - set cover bit [A][B]; increment cover_count_o only if the bit was previously clear;
  - set busy.
- Start while busy: start_i=1 with ready_o_mon=0 is ignored by the DUT; the checker keeps the original operands.
  - If op_state_i==ADD, set start_add_cov_o; if SHIFT, set start_shift_cov_o.
- BAD_PRODUCT: on a clk where busy=1 and done_o_mon=1, compare product_o_mon against A*B (full 2*WIDTH-bit unsigned product).
  - Mismatch: bp_err_o pulses the next cycle and bp_count_o increments.
  - Either way busy clears and the ready check is armed.
  - done_o_mon with busy=0 is not checked.
- NOT_READY: ready_o_mon must be 1 in the cycle after a done cycle, and in the first cycle after dut_reset_n_i rises.
  - Otherwise nr_err_o pulses the next cycle and nr_count_o increments.
  - Each arm fires at most once.
- DUT reset mid-operation:
  - Sampled each clk while dut_reset_n_i=0. If op_state_i was ADD or SHIFT in the last cycle before dut_reset_n_i fell, set reset_add_cov_o / reset_shift_cov_o. Track this with a registered copy of op_state_i.
  - busy and pending checks clear; no error is raised for the aborted operation.
  - The cover bitmap and counters are retained.
- Counters saturate at 2^CNT_W-1; they never wrap.
- A BAD_PRODUCT and a NOT_READY in the same cycle both pulse and both count.
- Error pulses are registered: 1-cycle latency from the offending sample edge.
- Cover bitmap is a 2^(2*WIDTH)-bit register array indexed {A,B}; cov_hit_o reads it combinationally.

Decomposition:
- Package mult_types:
  - typedef mult_op_t enum logic[1:0] {NONE=0, ADD=1, SHIFT=2};
  - WIDTH-based operand_t / product_t typedefs;
  - OPERAND_LIMIT = 2^WIDTH constant.
- One natural sub-module: mult_cover_bitmap (set port, query port, new-hit flag, popcount counter).

Test Plan:
- Checker reset, DUT ready, start 3*5, DUT returns 15 with done → bp_err_o never pulses; cover_count_o=1; cov_hit_o=1 for query (3,5).
- Start 255*255, DUT returns 16'hFE00 instead of 16'hFE01 → bp_err_o pulses once the cycle after done; bp_count_o=1.
- Repeat 3*5 twice → cover_count_o stays 1.
- dut_reset_n_i low while op_state_i=ADD, then later while SHIFT → reset_add_cov_o=1 and reset_shift_cov_o=1. No BAD_PRODUCT for the aborted ops; cover bitmap unchanged.
- start_i pulsed during ADD and during SHIFT of a 7*9 op → start_add_cov_o=1 and start_shift_cov_o=1. Product still checked against 63.
- ready_o_mon held 0 the cycle after done, and again after dut_reset_n_i release → nr_err_o pulses twice; nr_count_o=2.

Source files
------------

// File: rtl/mult_txn_checker_pkg.sv
// Shared types for the add-shift multiplier and its transaction checker.
package mult_types;

    // Operand width of the multiplier this package describes.
    localparam int MULT_WIDTH = 8;

    // Number of distinct values one operand can take.
    localparam int OPERAND_LIMIT = 1 << MULT_WIDTH;

    // Internal operation phase exported by the multiplier.
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2
    } mult_op_t;

    typedef logic [MULT_WIDTH-1:0]   operand_t;
    typedef logic [2*MULT_WIDTH-1:0] product_t;

endpackage

// File: rtl/mult_txn_checker_cover.sv
// Operand-pair cover bitmap: one bit per {A,B}, with a combinational query
// port and a running count of distinct pairs seen.
module mult_cover_bitmap
    import mult_types::*;
#(
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] query_idx,
    output logic             query_hit,
    output logic [IDX_W:0]   count
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] bitmap_reg;
    logic             new_hit;

    // A set only counts when the bit was still clear before this edge.
    assign new_hit   = set_en & ~bitmap_reg[set_idx];
    assign query_hit = bitmap_reg[query_idx];

    // Mark covered pairs; bits are only ever set, never cleared, outside reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_reg <= '0;
        end else if (set_en) begin
            bitmap_reg[set_idx] <= 1'b1;
        end
    end

    // Popcount maintained incrementally; it cannot exceed DEPTH so no saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (new_hit) begin
            count <= count + (IDX_W + 1)'(1);
        end
    end

endmodule

// File: rtl/mult_txn_checker.sv
// On-chip scoreboard for the add-shift multiplier: checks products and ready
// behaviour, counts protocol errors, and records functional coverage.
module mult_txn_checker
    import mult_types::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               dut_reset_n_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    input  logic               start_i,
    input  logic               ready_o_mon,
    input  logic               done_o_mon,
    input  logic [2*WIDTH-1:0] product_o_mon,
    input  logic [1:0]         op_state_i,
    output logic               bp_err_o,
    output logic               nr_err_o,
    output logic [CNT_W-1:0]   bp_count_o,
    output logic [CNT_W-1:0]   nr_count_o,
    output logic [2*WIDTH:0]   cover_count_o,
    output logic               all_covered_o,
    output logic               reset_add_cov_o,
    output logic               reset_shift_cov_o,
    output logic               start_add_cov_o,
    output logic               start_shift_cov_o,
    input  logic [WIDTH-1:0]   cov_qa_i,
    input  logic [WIDTH-1:0]   cov_qb_i,
    output logic               cov_hit_o
);

    localparam int PROD_W = 2 * WIDTH;

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              busy_reg;
    logic              done_arm_reg;
    logic              rst_arm_reg;
    logic              dut_rst_prev_reg;
    logic [1:0]        op_prev_reg;

    logic [PROD_W-1:0] expected_product;
    logic              accept;
    logic              check_done;
    logic              bad_product;
    logic              not_ready;
    logic              start_busy;
    logic              reset_fall;

    assign expected_product = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};

    // Everything the DUT does while its own reset is low is ignored.
    assign accept      = dut_reset_n_i & start_i & ready_o_mon;
    assign check_done  = dut_reset_n_i & busy_reg & done_o_mon;
    assign bad_product = check_done & (product_o_mon != expected_product);
    // Both arms share one pulse; they cannot meaningfully overlap anyway.
    assign not_ready   = dut_reset_n_i & (done_arm_reg | rst_arm_reg) & ~ready_o_mon;
    assign start_busy  = dut_reset_n_i & start_i & ~ready_o_mon;
    // First sample with the DUT reset low; op_prev_reg then holds the last live phase.
    assign reset_fall  = ~dut_reset_n_i & dut_rst_prev_reg;

    // Transaction tracking: operand latch, busy, ready-check arms and error pulses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            a_reg            <= '0;
            b_reg            <= '0;
            busy_reg         <= 1'b0;
            done_arm_reg     <= 1'b0;
            rst_arm_reg      <= 1'b0;
            dut_rst_prev_reg <= 1'b0;
            op_prev_reg      <= 2'd0;
            bp_err_o         <= 1'b0;
            nr_err_o         <= 1'b0;
        end else begin
            dut_rst_prev_reg <= dut_reset_n_i;
            op_prev_reg      <= op_state_i;
            bp_err_o         <= bad_product;
            nr_err_o         <= not_ready;
            if (!dut_reset_n_i) begin
                // Aborted operation: drop it silently and check ready on release.
                busy_reg     <= 1'b0;
                done_arm_reg <= 1'b0;
                rst_arm_reg  <= 1'b1;
            end else begin
                rst_arm_reg  <= 1'b0;
                done_arm_reg <= check_done;
                if (check_done) begin
                    busy_reg <= 1'b0;
                end
                if (accept) begin
                    busy_reg <= 1'b1;
                    a_reg    <= multiplicand_i;
                    b_reg    <= multiplier_i;
                end
            end
        end
    end

    // Sticky event covers for reset and start landing mid-operation.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            reset_add_cov_o   <= 1'b0;
            reset_shift_cov_o <= 1'b0;
            start_add_cov_o   <= 1'b0;
            start_shift_cov_o <= 1'b0;
        end else begin
            if (reset_fall && op_prev_reg == ADD) begin
                reset_add_cov_o <= 1'b1;
            end
            if (reset_fall && op_prev_reg == SHIFT) begin
                reset_shift_cov_o <= 1'b1;
            end
            if (start_busy && op_state_i == ADD) begin
                start_add_cov_o <= 1'b1;
            end
            if (start_busy && op_state_i == SHIFT) begin
                start_shift_cov_o <= 1'b1;
            end
        end
    end

    // Saturating error counters; simultaneous errors each count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bp_count_o <= '0;
            nr_count_o <= '0;
        end else begin
            if (bad_product && bp_count_o != '1) begin
                bp_count_o <= bp_count_o + CNT_W'(1);
            end
            if (not_ready && nr_count_o != '1) begin
                nr_count_o <= nr_count_o + CNT_W'(1);
            end
        end
    end

    mult_cover_bitmap #(
        .IDX_W (PROD_W)
    ) u_cover (
        .clk       (clk_i),
        .rst_n     (reset_n_i),
        .set_en    (accept),
        .set_idx   ({multiplicand_i, multiplier_i}),
        .query_idx ({cov_qa_i, cov_qb_i}),
        .query_hit (cov_hit_o),
        .count     (cover_count_o)
    );

    // The count tops out at exactly 2^(2*WIDTH), the only value with the MSB set.
    assign all_covered_o = cover_count_o[PROD_W];

endmodule

// File: tb/tb_mult_txn_checker.sv
// Directed bench for mult_txn_checker: drives the multiplier pins by hand and
// scoreboards the error pulses against hand-computed expectations.
module tb_mult_txn_checker;
    import mult_types::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               dut_reset_n;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic               start;
    logic               ready;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [1:0]         op;
    logic               bp_err_o;
    logic               nr_err_o;
    logic [CNT_W-1:0]   bp_count_o;
    logic [CNT_W-1:0]   nr_count_o;
    logic [2*WIDTH:0]   cover_count_o;
    logic               all_covered_o;
    logic               reset_add_cov_o;
    logic               reset_shift_cov_o;
    logic               start_add_cov_o;
    logic               start_shift_cov_o;
    logic [WIDTH-1:0]   qa;
    logic [WIDTH-1:0]   qb;
    logic               cov_hit_o;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t bp_q[$];
    exp_t nr_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   pcyc = 0;
    int   exp_bp = 0;
    int   exp_nr = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    mult_txn_checker #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .dut_reset_n_i     (dut_reset_n),
        .multiplicand_i    (ma),
        .multiplier_i      (mb),
        .start_i           (start),
        .ready_o_mon       (ready),
        .done_o_mon        (done),
        .product_o_mon     (product),
        .op_state_i        (op),
        .bp_err_o          (bp_err_o),
        .nr_err_o          (nr_err_o),
        .bp_count_o        (bp_count_o),
        .nr_count_o        (nr_count_o),
        .cover_count_o     (cover_count_o),
        .all_covered_o     (all_covered_o),
        .reset_add_cov_o   (reset_add_cov_o),
        .reset_shift_cov_o (reset_shift_cov_o),
        .start_add_cov_o   (start_add_cov_o),
        .start_shift_cov_o (start_shift_cov_o),
        .cov_qa_i          (qa),
        .cov_qb_i          (qb),
        .cov_hit_o         (cov_hit_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    // Expected pulse is seen at the negedge after the posedge that samples the
    // inputs being driven now.
    task automatic push_bp();
        exp_t t;
        exp_bp++;
        t.cyc = pcyc + 1;
        t.cnt = exp_bp;
        bp_q.push_back(t);
    endtask

    task automatic push_nr();
        exp_t t;
        exp_nr++;
        t.cyc = pcyc + 1;
        t.cnt = exp_nr;
        nr_q.push_back(t);
    endtask

    task automatic query(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic exp);
        qa = a;
        qb = b;
        #1;
        check(name, {31'd0, cov_hit_o}, {31'd0, exp});
    endtask

    // Monitor: every error pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bp_err_o !== 1'b0) begin
                if (bp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL bp_unexpected: bp_err_o got %b required 0 (cycle %0d)", bp_err_o, pcyc);
                end else begin
                    mon_e = bp_q.pop_front();
                    check("bp_pulse_cycle", pcyc, mon_e.cyc);
                    check("bp_count_at_pulse", {16'd0, bp_count_o}, mon_e.cnt);
                end
            end
            if (nr_err_o !== 1'b0) begin
                if (nr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL nr_unexpected: nr_err_o got %b required 0 (cycle %0d)", nr_err_o, pcyc);
                end else begin
                    mon_e = nr_q.pop_front();
                    check("nr_pulse_cycle", pcyc, mon_e.cyc);
                    check("nr_count_at_pulse", {16'd0, nr_count_o}, mon_e.cnt);
                end
            end
        end
    end

    // One complete multiply: accept, ADD, SHIFT, done, then two ready cycles.
    // With poke, start is re-asserted (with different operands) while busy.
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic [15:0] prod,
                          input bit bad, input bit poke, input bit ready_after);
        @(negedge clk);
        ma = oa; mb = ob; start = 1'b1; ready = 1'b1; done = 1'b0; op = NONE;
        @(negedge clk);
        start = poke; ready = 1'b0; op = ADD;
        if (poke) begin
            ma = 8'd1; mb = 8'd1;
        end
        @(negedge clk);
        op = SHIFT;
        @(negedge clk);
        start = 1'b0; op = NONE; done = 1'b1; product = prod;
        if (bad) push_bp();
        @(negedge clk);
        done = 1'b0; ready = ready_after;
        if (!ready_after) push_nr();
        @(negedge clk);
        ready = ready_after;
        @(negedge clk);
        ready = 1'b1;
        $display("op %0d*%0d product %04h bad=%0d poke=%0d ready_after=%0d", oa, ob, prod, bad, poke, ready_after);
    endtask

    // Accept an operation then pull the DUT reset during ADD (or SHIFT).
    // Afterwards a stray done with a wrong product must not be checked.
    task automatic abort_op(input logic [7:0] oa, input logic [7:0] ob, input bit in_shift,
                            input bit ready_after);
        @(negedge clk);
        ma = oa; mb = ob; start = 1'b1; ready = 1'b1; done = 1'b0; op = NONE;
        @(negedge clk);
        start = 1'b0; ready = 1'b0; op = ADD;
        if (in_shift) begin
            @(negedge clk);
            op = SHIFT;
        end
        @(negedge clk);
        dut_reset_n = 1'b0; op = NONE;
        @(negedge clk);
        @(negedge clk);
        dut_reset_n = 1'b1; ready = ready_after;
        if (!ready_after) push_nr();
        @(negedge clk);
        ready = ready_after;
        @(negedge clk);
        ready = 1'b1; done = 1'b1; product = 16'h1234;
        @(negedge clk);
        done = 1'b0;
        $display("abort %0d*%0d in_shift=%0d ready_after=%0d", oa, ob, in_shift, ready_after);
    endtask

    initial begin
        reset_n = 1'b0; dut_reset_n = 1'b1;
        ma = '0; mb = '0; start = 1'b0; ready = 1'b1; done = 1'b0;
        product = '0; op = NONE; qa = 8'd3; qb = 8'd5;

        repeat (3) @(negedge clk);
        check("reset_bp_err", {31'd0, bp_err_o}, 32'd0);
        check("reset_nr_err", {31'd0, nr_err_o}, 32'd0);
        check("reset_bp_count", {16'd0, bp_count_o}, 32'd0);
        check("reset_nr_count", {16'd0, nr_count_o}, 32'd0);
        check("reset_cover_count", {15'd0, cover_count_o}, 32'd0);
        check("reset_covers", {27'd0, all_covered_o, reset_add_cov_o, reset_shift_cov_o,
                               start_add_cov_o, start_shift_cov_o}, 32'd0);
        query("reset_cov_hit", 8'd3, 8'd5, 1'b0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Good 3*5
        run_op(8'd3, 8'd5, 16'd15, 1'b0, 1'b0, 1'b1);
        check("t1_cover_count", {15'd0, cover_count_o}, 32'd1);
        check("t1_bp_count", {16'd0, bp_count_o}, 32'd0);
        query("t1_hit_3_5", 8'd3, 8'd5, 1'b1);
        query("t1_hit_5_3", 8'd5, 8'd3, 1'b0);

        // 255*255 = FE01, DUT returns FE00
        run_op(8'd255, 8'd255, 16'hFE00, 1'b1, 1'b0, 1'b1);
        check("t2_bp_count", {16'd0, bp_count_o}, 32'd1);
        check("t2_cover_count", {15'd0, cover_count_o}, 32'd2);

        // Repeated pair does not grow coverage
        run_op(8'd3, 8'd5, 16'd15, 1'b0, 1'b0, 1'b1);
        run_op(8'd3, 8'd5, 16'd15, 1'b0, 1'b0, 1'b1);
        check("t3_cover_count", {15'd0, cover_count_o}, 32'd2);

        // DUT reset mid-operation
        abort_op(8'd3, 8'd5, 1'b0, 1'b1);
        check("t4_reset_add", {31'd0, reset_add_cov_o}, 32'd1);
        check("t4_reset_shift_pre", {31'd0, reset_shift_cov_o}, 32'd0);
        abort_op(8'd255, 8'd255, 1'b1, 1'b1);
        check("t4_reset_shift", {31'd0, reset_shift_cov_o}, 32'd1);
        check("t4_bp_count", {16'd0, bp_count_o}, 32'd1);
        check("t4_nr_count", {16'd0, nr_count_o}, 32'd0);
        check("t4_cover_count", {15'd0, cover_count_o}, 32'd2);
        query("t4_hit_255_255", 8'd255, 8'd255, 1'b1);

        // Start while busy; checker keeps 7*9 = 63
        check("t5_start_covers_pre", {30'd0, start_add_cov_o, start_shift_cov_o}, 32'd0);
        run_op(8'd7, 8'd9, 16'd63, 1'b0, 1'b1, 1'b1);
        check("t5_start_add", {31'd0, start_add_cov_o}, 32'd1);
        check("t5_start_shift", {31'd0, start_shift_cov_o}, 32'd1);
        check("t5_bp_count", {16'd0, bp_count_o}, 32'd1);
        check("t5_cover_count", {15'd0, cover_count_o}, 32'd3);
        query("t5_hit_1_1", 8'd1, 8'd1, 1'b0);
        // Returning 1*1 for a 7*9 op is a bad product
        run_op(8'd7, 8'd9, 16'd1, 1'b1, 1'b1, 1'b1);
        check("t5_bp_count_bad", {16'd0, bp_count_o}, 32'd2);

        // NOT_READY after done and after DUT reset release
        run_op(8'd2, 8'd3, 16'd6, 1'b0, 1'b0, 1'b0);
        check("t6_nr_count_done", {16'd0, nr_count_o}, 32'd1);
        check("t6_cover_count", {15'd0, cover_count_o}, 32'd4);
        abort_op(8'd2, 8'd3, 1'b0, 1'b0);
        check("t6_nr_count_reset", {16'd0, nr_count_o}, 32'd2);

        repeat (3) @(negedge clk);
        check("end_bp_queue_empty", bp_q.size(), 32'd0);
        check("end_nr_queue_empty", nr_q.size(), 32'd0);
        check("end_bp_count", {16'd0, bp_count_o}, 32'd2);
        check("end_nr_count", {16'd0, nr_count_o}, 32'd2);
        check("end_cover_count", {15'd0, cover_count_o}, 32'd4);
        check("end_all_covered", {31'd0, all_covered_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
